// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU sizing constants used by the register file and its scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned CPU_XLEN     = 32;
    localparam int unsigned CPU_NUM_REGS = 32;
    localparam int unsigned CPU_AW       = 5;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer bit per architectural register, with set/clear/flush priority and idle view.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = CPU_NUM_REGS,
    parameter int unsigned AW       = CPU_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_addr_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                idle_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (wr_en_i) begin
                pending_d[wr_addr_i] = 1'b0;
            end
            // Set after clear: a newer producer outranks the retiring one.
            if (issue_en_i && (issue_addr_i != '0)) begin
                pending_d[issue_addr_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign idle_o    = ~|pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write flop register file with write-through bypass and producer scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN     = CPU_XLEN,
    parameter int unsigned NUM_REGS = CPU_NUM_REGS,
    parameter int unsigned AW       = CPU_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [AW-1:0]   rd_addr_a_i,
    input  logic [AW-1:0]   rd_addr_b_i,
    output logic [XLEN-1:0] rd_data_a_o,
    output logic [XLEN-1:0] rd_data_b_o,
    output logic            busy_a_o,
    output logic            busy_b_o,
    input  logic            issue_en_i,
    input  logic [AW-1:0]   issue_addr_i,
    input  logic            flush_i,
    output logic            idle_o
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                hit_a;
    logic                hit_b;

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i && (wr_addr_i != '0)) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_reg_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .pending_o    (pending),
        .idle_o       (idle_o)
    );

    // A same-cycle write to a source register is forwarded and therefore not busy.
    assign hit_a = wr_en_i && (wr_addr_i == rd_addr_a_i);
    assign hit_b = wr_en_i && (wr_addr_i == rd_addr_b_i);

    always_comb begin
        rd_data_a_o = '0;
        rd_data_b_o = '0;
        busy_a_o    = 1'b0;
        busy_b_o    = 1'b0;
        if (rd_addr_a_i != '0) begin
            rd_data_a_o = hit_a ? wr_data_i : regs_q[rd_addr_a_i];
            busy_a_o    = pending[rd_addr_a_i] && !hit_a;
        end
        if (rd_addr_b_i != '0) begin
            rd_data_b_o = hit_b ? wr_data_i : regs_q[rd_addr_b_i];
            busy_b_o    = pending[rd_addr_b_i] && !hit_b;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized check of regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic [4:0]  rd_addr_a_i;
    logic [4:0]  rd_addr_b_i;
    logic [31:0] rd_data_a_o;
    logic [31:0] rd_data_b_o;
    logic        busy_a_o;
    logic        busy_b_o;
    logic        issue_en_i;
    logic [4:0]  issue_addr_i;
    logic        flush_i;
    logic        idle_o;

    int unsigned n_vec;
    int unsigned n_err;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_scoreboard u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rd_addr_a_i  (rd_addr_a_i),
        .rd_addr_b_i  (rd_addr_b_i),
        .rd_data_a_o  (rd_data_a_o),
        .rd_data_b_o  (rd_data_b_o),
        .busy_a_o     (busy_a_o),
        .busy_b_o     (busy_b_o),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .idle_o       (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (wr_en_i && wr_addr_i == a) return wr_data_i;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (wr_en_i && wr_addr_i == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic exp_idle();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rd_a"}, rd_data_a_o, exp_rd(rd_addr_a_i));
        check({tag, ".rd_b"}, rd_data_b_o, exp_rd(rd_addr_b_i));
        check({tag, ".busy_a"}, {31'b0, busy_a_o}, {31'b0, exp_busy(rd_addr_a_i)});
        check({tag, ".busy_b"}, {31'b0, busy_b_o}, {31'b0, exp_busy(rd_addr_b_i)});
        check({tag, ".idle"}, {31'b0, idle_o}, {31'b0, exp_idle()});
    endtask

    // Advance the model by one clock edge with the currently applied inputs, then the DUT.
    task automatic tick();
        if (wr_en_i && wr_addr_i != 0) m_regs[wr_addr_i] = wr_data_i;
        if (flush_i) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (wr_en_i) m_pend[wr_addr_i] = 1'b0;
            if (issue_en_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_i      = 1'b0;
        wr_addr_i    = '0;
        wr_data_i    = '0;
        issue_en_i   = 1'b0;
        issue_addr_i = '0;
        flush_i      = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        idle_inputs();
        rd_addr_a_i = 5'd1;
        rd_addr_b_i = 5'd2;
        rst_n       = 1'b0;
        #12;
        check_all("reset");
        rst_n = 1'b1;
        #1;
        check_all("out_of_reset");
        tick();

        // Write then read on both ports
        wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd5; rd_addr_b_i = 5'd5;
        #1;
        check("x5.rd_a", rd_data_a_o, 32'hDEADBEEF);
        check("x5.rd_b", rd_data_b_o, 32'hDEADBEEF);
        check("x5.busy", {30'b0, busy_a_o, busy_b_o}, 32'h0);

        // Register 0 is immune to writes and issues
        wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'h12345678;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd0;
        #1;
        check("x0.rd_a", rd_data_a_o, 32'h0);
        issue_en_i = 1'b1; issue_addr_i = 5'd0;
        tick();
        idle_inputs();
        check("x0.idle", {31'b0, idle_o}, 32'h1);

        // Issue, wait, then bypassed writeback
        issue_en_i = 1'b1; issue_addr_i = 5'd7;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd7;
        #1;
        check("x7.busy_c1", {31'b0, busy_a_o}, 32'h1);
        tick();
        tick();
        wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'hA5A5A5A5;
        #1;
        check("x7.bypass", rd_data_a_o, 32'hA5A5A5A5);
        check("x7.busy_c3", {31'b0, busy_a_o}, 32'h0);
        check("x7.idle_c3", {31'b0, idle_o}, 32'h0);
        tick();
        idle_inputs();
        check("x7.idle_c4", {31'b0, idle_o}, 32'h1);

        // Same-cycle set and clear: set wins
        issue_en_i = 1'b1; issue_addr_i = 5'd9;
        wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'h1;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd9;
        #1;
        check("x9.rd", rd_data_a_o, 32'h1);
        check("x9.busy", {31'b0, busy_a_o}, 32'h1);
        tick();
        wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'h2;
        tick();
        idle_inputs();
        check("x9.busy_after", {31'b0, busy_a_o}, 32'h0);

        // Flush beats a concurrent issue
        issue_en_i = 1'b1;
        issue_addr_i = 5'd3; tick();
        issue_addr_i = 5'd4; tick();
        issue_addr_i = 5'd5; tick();
        flush_i = 1'b1; issue_addr_i = 5'd6;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd6; rd_addr_b_i = 5'd3;
        #1;
        check("flush.busy_6_3", {30'b0, busy_a_o, busy_b_o}, 32'h0);
        check("flush.idle", {31'b0, idle_o}, 32'h1);
        rd_addr_a_i = 5'd4; rd_addr_b_i = 5'd5;
        #1;
        check("flush.busy_4_5", {30'b0, busy_a_o, busy_b_o}, 32'h0);

        // Asynchronous reset between edges
        wr_en_i = 1'b1; wr_addr_i = 5'd10; wr_data_i = 32'hFFFFFFFF;
        issue_en_i = 1'b1; issue_addr_i = 5'd11;
        tick();
        idle_inputs();
        rd_addr_a_i = 5'd10; rd_addr_b_i = 5'd11;
        #1;
        check("x10.before", rd_data_a_o, 32'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        check("x10.async_rd", rd_data_a_o, 32'h0);
        check("x10.async_idle", {31'b0, idle_o}, 32'h1);
        model_clear();
        rst_n = 1'b1;
        tick();
        check_all("after_async_reset");

        // Randomized traffic, addresses biased toward a small window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            wr_en_i      = 1'($urandom_range(0, 1));
            wr_addr_i    = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wr_data_i    = $urandom;
            issue_en_i   = 1'($urandom_range(0, 1));
            issue_addr_i = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            flush_i      = ($urandom_range(0, 15) == 0);
            rd_addr_a_i  = 5'($urandom_range(0, 7));
            rd_addr_b_i  = 5'(($urandom_range(0, 1) == 0) ? wr_addr_i : $urandom_range(0, 31));
            #1;
            check_all("rand");
            if ($urandom_range(0, 99) == 0) begin
                idle_inputs();
                rst_n = 1'b0;
                #1;
                model_clear();
                check_all("rand_rst");
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
